// File: rtl/pwm_pkg.sv
// Shared definitions for the pulse width meter: default sizes, a
// constant-evaluable clog2 and the {chan, width} event record.
package pwm_pkg;

  localparam int WIDTH_DEF  = 48;
  localparam int CNT_W_DEF  = 8;
  localparam int DROP_W_DEF = 16;

  // A result of 0 would mean a zero-width index, so the minimum is 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int CH_W_DEF = clog2(WIDTH_DEF);

  typedef struct packed {
    logic [CH_W_DEF-1:0]  chan;
    logic [CNT_W_DEF-1:0] width;
  } ev_t;

endpackage

// File: rtl/pulse_width_chan.sv
// One channel of the meter: edge detect, high-time counter and a
// single-entry pending slot for the completed width.
module pulse_width_chan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             pop,
  output logic             pend,
  output logic [CNT_W-1:0] pend_w,
  output logic             drop
);

  logic             in_d;
  logic             track;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             fall;
  logic             load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign rise = sig & ~in_d;
  assign fall = ~sig & in_d;
  // A popped slot is free again in the same cycle, so a fall can refill it.
  assign load = fall & track & (~pend | pop);
  assign drop = fall & track & pend & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_d  <= 1'b1;
      track <= 1'b0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      in_d <= sig;
      if (rise) begin
        cnt   <= CNT_W'(1);
        track <= 1'b1;
      end else if (sig && track) begin
        cnt <= sat_inc(cnt);
      end
      if (fall) track <= 1'b0;
      if (load)     pend <= 1'b1;
      else if (pop) pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) pend_w <= cnt;
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Per-channel pulse width measurement with a round-robin arbiter feeding a
// single valid/ready event register, plus sticky drop bookkeeping.
module pulse_width_meter import pwm_pkg::*; #(
  parameter int  WIDTH  = WIDTH_DEF,
  parameter int  CNT_W  = CNT_W_DEF,
  parameter int  DROP_W = DROP_W_DEF,
  localparam int CH_W   = clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sig_in,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CH_W-1:0]   ev_chan,
  output logic [CNT_W-1:0]  ev_width,
  output logic [WIDTH-1:0]  ovf_flags,
  input  logic              clr_ovf,
  output logic [DROP_W-1:0] drop_count
);

  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] drop;
  logic [WIDTH-1:0] pop;
  logic [CNT_W-1:0] pend_w [WIDTH];
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  sel;
  logic [CH_W-1:0]  idx;
  logic             found;
  logic             load;
  logic [CH_W:0]    drop_n;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [CH_W:0]     b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(b);
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    pulse_width_chan #(.CNT_W(CNT_W)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .sig    (sig_in[g]),
      .pop    (pop[g]),
      .pend   (pend[g]),
      .pend_w (pend_w[g]),
      .drop   (drop[g])
    );
  end

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      idx = CH_W'((int'(rr_ptr) + i) % WIDTH);
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign load = ~ev_valid | ev_ready;

  always_comb begin
    pop = '0;
    if (load && found) pop[sel] = 1'b1;
  end

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < WIDTH; i++) drop_n = drop_n + (CH_W+1)'(drop[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_chan  <= '0;
      ev_width <= '0;
      rr_ptr   <= CH_W'(WIDTH - 1);
    end else if (load) begin
      ev_valid <= found;
      if (found) begin
        ev_chan  <= sel;
        ev_width <= pend_w[sel];
        rr_ptr   <= sel;
      end
    end
  end

  // A drop landing on the clear strobe survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flags  <= '0;
      drop_count <= '0;
    end else if (clr_ovf) begin
      ovf_flags  <= drop;
      drop_count <= sat_add('0, drop_n);
    end else begin
      ovf_flags  <= ovf_flags | drop;
      drop_count <= sat_add(drop_count, drop_n);
    end
  end

endmodule
